// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates cache-line fetch, load and store requests onto a
// single-outstanding byte-serial memory-controller command port.
// Ports:
//   clk, rst (async, active-low), rdy (0 freezes), rollback (flush spec traffic)
//   if_req/if_addr -> if_done      fetch requester (full line, mc_len=0)
//   ld_req/ld_addr/ld_len -> ld_done
//   st_req/st_addr/st_len/st_wdata -> st_done
//   mc_en/mc_wr/mc_addr/mc_len/mc_wdata -> controller, mc_done <- controller
module mem_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              rollback,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [2:0]        ld_len,
  output logic              ld_done,
  input  logic              st_req,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [2:0]        st_len,
  input  logic [31:0]       st_wdata,
  output logic              st_done,
  output logic              mc_en,
  output logic              mc_wr,
  output logic [ADDR_W-1:0] mc_addr,
  output logic [2:0]        mc_len,
  output logic [31:0]       mc_wdata,
  input  logic              mc_done
);

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DRAIN, S_DONE} state_t;
  typedef enum logic [1:0] {OWN_IF, OWN_LD, OWN_ST} owner_t;

  state_t            r_state, w_state;
  owner_t            r_owner, w_owner;
  logic [2:0]        r_starve, w_starve;
  logic              r_pend, w_pend;
  logic              r_mc_en, w_mc_en;
  logic              r_mc_wr, w_mc_wr;
  logic [ADDR_W-1:0] r_mc_addr, w_mc_addr;
  logic [2:0]        r_mc_len, w_mc_len;
  logic [31:0]       r_mc_wdata, w_mc_wdata;
  logic              r_if_done, w_if_done;
  logic              r_ld_done, w_ld_done;
  logic              r_st_done, w_st_done;
  logic              w_mc_done;
  logic              w_gnt_if, w_gnt_ld, w_gnt_st;

  // Unsupported lengths are issued as a full word.
  function automatic logic [2:0] norm_len(input logic [2:0] len);
    return (len == 3'd1 || len == 3'd2 || len == 3'd4) ? len : 3'd4;
  endfunction

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_owner    <= OWN_IF;
      r_starve   <= 3'd0;
      r_pend     <= 1'b0;
      r_mc_en    <= 1'b0;
      r_mc_wr    <= 1'b0;
      r_mc_addr  <= '0;
      r_mc_len   <= 3'd0;
      r_mc_wdata <= 32'd0;
      r_if_done  <= 1'b0;
      r_ld_done  <= 1'b0;
      r_st_done  <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_owner    <= w_owner;
      r_starve   <= w_starve;
      r_pend     <= w_pend;
      r_mc_en    <= w_mc_en;
      r_mc_wr    <= w_mc_wr;
      r_mc_addr  <= w_mc_addr;
      r_mc_len   <= w_mc_len;
      r_mc_wdata <= w_mc_wdata;
      r_if_done  <= w_if_done;
      r_ld_done  <= w_ld_done;
      r_st_done  <= w_st_done;
    end
  end

  // Next-state, grant selection and command/done generation.
  always_comb begin
    w_state    = r_state;
    w_owner    = r_owner;
    w_starve   = r_starve;
    w_pend     = r_pend;
    w_mc_en    = r_mc_en;
    w_mc_wr    = r_mc_wr;
    w_mc_addr  = r_mc_addr;
    w_mc_len   = r_mc_len;
    w_mc_wdata = r_mc_wdata;
    w_if_done  = 1'b0;
    w_ld_done  = 1'b0;
    w_st_done  = 1'b0;
    w_gnt_if   = 1'b0;
    w_gnt_ld   = 1'b0;
    w_gnt_st   = 1'b0;
    // A completion seen while frozen is remembered until rdy returns.
    w_mc_done  = mc_done | r_pend;

    if (!rdy) begin
      w_pend = r_pend | mc_done;
    end else begin
      w_pend = 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (r_starve == LIMIT && if_req && !rollback) w_gnt_if = 1'b1;
          else if (st_req)                              w_gnt_st = 1'b1;
          else if (ld_req && !rollback)                 w_gnt_ld = 1'b1;
          else if (if_req && !rollback)                 w_gnt_if = 1'b1;

          if (!if_req || w_gnt_if) w_starve = 3'd0;
          else if ((w_gnt_st || w_gnt_ld) && r_starve < LIMIT)
            w_starve = r_starve + 3'd1;

          if (w_gnt_if) begin
            w_owner    = OWN_IF;
            w_mc_addr  = if_addr;
            w_mc_len   = 3'd0;
            w_mc_wdata = 32'd0;
          end else if (w_gnt_ld) begin
            w_owner    = OWN_LD;
            w_mc_addr  = ld_addr;
            w_mc_len   = norm_len(ld_len);
            w_mc_wdata = 32'd0;
          end else if (w_gnt_st) begin
            w_owner    = OWN_ST;
            w_mc_addr  = st_addr;
            w_mc_len   = norm_len(st_len);
            w_mc_wdata = st_wdata;
          end
          if (w_gnt_if || w_gnt_ld || w_gnt_st) begin
            w_state = S_BUSY;
            w_mc_en = 1'b1;
            w_mc_wr = w_gnt_st;
          end
        end
        S_BUSY: begin
          if (w_mc_done) begin
            w_state = S_DONE;
            w_mc_en = 1'b0;
            w_mc_wr = 1'b0;
            // Stores are committed and always acknowledged.
            w_if_done = (r_owner == OWN_IF) && !rollback;
            w_ld_done = (r_owner == OWN_LD) && !rollback;
            w_st_done = (r_owner == OWN_ST);
          end else if (rollback && r_owner != OWN_ST) begin
            w_state = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_mc_done) begin
            w_state = S_DONE;
            w_mc_en = 1'b0;
            w_mc_wr = 1'b0;
          end
        end
        S_DONE: w_state = S_IDLE;
        default: w_state = S_IDLE;
      endcase
    end
  end

  assign if_done  = r_if_done;
  assign ld_done  = r_ld_done;
  assign st_done  = r_st_done;
  assign mc_en    = r_mc_en;
  assign mc_wr    = r_mc_wr;
  assign mc_addr  = r_mc_addr;
  assign mc_len   = r_mc_len;
  assign mc_wdata = r_mc_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table vectors, directed corner sequences and a randomized
// run against a transaction-level arbitration model.
module tb_mem_arbiter;
  localparam int unsigned AW  = 32;
  localparam int unsigned LIM = 4;

  logic          clk, rst, rdy, rollback;
  logic          if_req, ld_req, st_req;
  logic [AW-1:0] if_addr, ld_addr, st_addr;
  logic [2:0]    ld_len, st_len;
  logic [31:0]   st_wdata;
  logic          if_done, ld_done, st_done;
  logic          mc_en, mc_wr, mc_done;
  logic [AW-1:0] mc_addr;
  logic [2:0]    mc_len;
  logic [31:0]   mc_wdata;

  mem_arbiter #(.ADDR_W(AW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_len(ld_len), .ld_done(ld_done),
    .st_req(st_req), .st_addr(st_addr), .st_len(st_len), .st_wdata(st_wdata),
    .st_done(st_done),
    .mc_en(mc_en), .mc_wr(mc_wr), .mc_addr(mc_addr), .mc_len(mc_len),
    .mc_wdata(mc_wdata), .mc_done(mc_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [2:0] oh(input int own);
    return (own == 0) ? 3'b100 : (own == 1) ? 3'b010 : (own == 2) ? 3'b001 : 3'b000;
  endfunction

  function automatic logic [2:0] exp_len(input logic [2:0] l);
    return (l == 3'd1 || l == 3'd2 || l == 3'd4) ? l : 3'd4;
  endfunction

  function automatic logic [2:0] dones();
    return {if_done, ld_done, st_done};
  endfunction

  // Wait for a grant, check it, complete it and optionally drop the request.
  task automatic serve(input int own, input logic [31:0] addr, input int exp_gap,
                       input bit drop, input string nm);
    int gap = 0;
    while (!mc_en && gap < 50) begin tick(); gap++; end
    chk({nm, "_gap"}, 64'(gap), 64'(exp_gap));
    chk({nm, "_addr"}, 64'(mc_addr), 64'(addr));
    chk({nm, "_wr"}, 64'(mc_wr), 64'(own == 2));
    tick();
    mc_done = 1'b1;
    tick();
    mc_done = 1'b0;
    chk({nm, "_done"}, 64'(dones()), 64'(oh(own)));
    chk({nm, "_en_off"}, 64'(mc_en), 64'd0);
    if (drop) begin
      if (own == 0) if_req = 1'b0;
      if (own == 1) ld_req = 1'b0;
      if (own == 2) st_req = 1'b0;
    end
  endtask

  typedef struct {
    logic       st, ld, ifr;
    logic [2:0] st_len, ld_len;
    logic       exp_wr;
    logic [31:0] exp_addr;
    logic [2:0] exp_len;
    int         exp_own;
  } vec_t;

  vec_t tbl[9];

  initial begin
    bit bad;
    int own, starve, busy_own, busy_cyc, mc_cnt;
    bit done_sent, prev_en, p_if, p_ld, p_st, dropped_if, dropped_ld, dropped_st;

    rst = 1'b0; rdy = 1'b1; rollback = 1'b0; mc_done = 1'b0;
    if_req = 1'b0; ld_req = 1'b0; st_req = 1'b0;
    if_addr = 32'h1000; ld_addr = 32'h3000; st_addr = 32'h2000;
    ld_len = 3'd4; st_len = 3'd4; st_wdata = 32'hDEADBEEF;

    tbl[0] = '{0, 0, 1, 4, 4, 0, 32'h1000, 0, 0};
    tbl[1] = '{0, 1, 0, 4, 1, 0, 32'h3000, 1, 1};
    tbl[2] = '{0, 1, 0, 4, 2, 0, 32'h3000, 2, 1};
    tbl[3] = '{1, 0, 0, 4, 4, 1, 32'h2000, 4, 2};
    tbl[4] = '{1, 0, 0, 3, 4, 1, 32'h2000, 4, 2};
    tbl[5] = '{0, 1, 0, 4, 0, 0, 32'h3000, 4, 1};
    tbl[6] = '{1, 1, 0, 1, 2, 1, 32'h2000, 1, 2};
    tbl[7] = '{0, 1, 1, 4, 7, 0, 32'h3000, 4, 1};
    tbl[8] = '{1, 1, 1, 2, 1, 1, 32'h2000, 2, 2};

    tick(); tick();
    chk("rst_mc_en", 64'(mc_en), 64'd0);
    chk("rst_mc_wr", 64'(mc_wr), 64'd0);
    chk("rst_mc_addr", 64'(mc_addr), 64'd0);
    chk("rst_mc_len", 64'(mc_len), 64'd0);
    chk("rst_mc_wdata", 64'(mc_wdata), 64'd0);
    chk("rst_dones", 64'(dones()), 64'd0);
    rst = 1'b1;

    // Table-driven single transactions from IDLE.
    foreach (tbl[i]) begin
      st_req = tbl[i].st; ld_req = tbl[i].ld; if_req = tbl[i].ifr;
      st_len = tbl[i].st_len; ld_len = tbl[i].ld_len;
      tick();
      chk($sformatf("tbl%0d_en", i), 64'(mc_en), 64'd1);
      chk($sformatf("tbl%0d_wr", i), 64'(mc_wr), 64'(tbl[i].exp_wr));
      chk($sformatf("tbl%0d_addr", i), 64'(mc_addr), 64'(tbl[i].exp_addr));
      chk($sformatf("tbl%0d_len", i), 64'(mc_len), 64'(tbl[i].exp_len));
      if (tbl[i].exp_own == 2) chk($sformatf("tbl%0d_wdata", i), 64'(mc_wdata), 64'hDEADBEEF);
      tick(); tick();
      mc_done = 1'b1;
      tick();
      mc_done = 1'b0;
      chk($sformatf("tbl%0d_done", i), 64'(dones()), 64'(oh(tbl[i].exp_own)));
      chk($sformatf("tbl%0d_en_off", i), 64'(mc_en), 64'd0);
      st_req = 1'b0; ld_req = 1'b0; if_req = 1'b0;
      tick();
      chk($sformatf("tbl%0d_pulse", i), 64'(dones()), 64'd0);
      tick();
    end
    st_len = 3'd4; ld_len = 3'd4;

    // Lone fetch with a long controller latency.
    if_req = 1'b1;
    tick();
    chk("fetch_en", 64'(mc_en), 64'd1);
    chk("fetch_wr", 64'(mc_wr), 64'd0);
    chk("fetch_addr", 64'(mc_addr), 64'h1000);
    chk("fetch_len", 64'(mc_len), 64'd0);
    bad = 0;
    for (int c = 0; c < 19; c++) begin
      tick();
      if (!mc_en || dones() != 3'b000) bad = 1;
    end
    chk("fetch_hold", 64'(bad), 64'd0);
    mc_done = 1'b1;
    tick();
    mc_done = 1'b0;
    chk("fetch_done", 64'(dones()), 64'b100);
    chk("fetch_en_off", 64'(mc_en), 64'd0);
    if_req = 1'b0;
    tick(); tick();

    // All three requesters at once: store, load, fetch order.
    st_req = 1'b1; ld_req = 1'b1; if_req = 1'b1;
    serve(2, 32'h2000, 1, 1, "ord_st");
    serve(1, 32'h3000, 2, 1, "ord_ld");
    serve(0, 32'h1000, 2, 1, "ord_if");
    tick(); tick();

    // Rollback during a load drains it silently; pending store wins next.
    ld_req = 1'b1;
    tick();
    chk("rb_ld_grant", 64'({mc_en, mc_wr}), 64'b10);
    tick();
    rollback = 1'b1;
    tick();
    rollback = 1'b0; ld_req = 1'b0; st_req = 1'b1;
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      if (!mc_en || ld_done) bad = 1;
      tick();
    end
    chk("rb_drain_hold", 64'(bad), 64'd0);
    mc_done = 1'b1;
    tick();
    mc_done = 1'b0;
    chk("rb_no_ld_done", 64'(dones()), 64'd0);
    chk("rb_en_off", 64'(mc_en), 64'd0);
    serve(2, 32'h2000, 2, 1, "rb_st");
    tick(); tick();

    // Rollback coinciding with a fetch completion suppresses if_done.
    if_req = 1'b1;
    tick(); tick();
    mc_done = 1'b1; rollback = 1'b1; if_req = 1'b0;
    tick();
    mc_done = 1'b0; rollback = 1'b0;
    chk("rb_coinc_done", 64'(dones()), 64'd0);
    chk("rb_coinc_en", 64'(mc_en), 64'd0);
    tick(); tick();

    // Starvation: fifth arbitration forces the fetch past a held store.
    st_req = 1'b1; if_req = 1'b1;
    serve(2, 32'h2000, 1, 0, "stv_st0");
    for (int k = 1; k < 4; k++) serve(2, 32'h2000, 2, 0, $sformatf("stv_st%0d", k));
    serve(0, 32'h1000, 2, 1, "stv_if");
    st_req = 1'b0;
    tick(); tick();

    // Completion arriving while frozen is acted on after rdy returns.
    ld_req = 1'b1;
    tick();
    rdy = 1'b0; mc_done = 1'b1;
    tick();
    mc_done = 1'b0;
    chk("frz_en", 64'(mc_en), 64'd1);
    tick();
    chk("frz_no_done", 64'({mc_en, dones()}), 64'b1000);
    rdy = 1'b1;
    tick();
    chk("frz_done", 64'({mc_en, dones()}), 64'b0010);
    ld_req = 1'b0;
    tick(); tick();

    // Reset mid-store with rdy toggling abandons the command.
    st_req = 1'b1;
    tick();
    chk("rst_st_grant", 64'({mc_en, mc_wr}), 64'b11);
    rdy = 1'b0; tick(); rdy = 1'b1; tick(); rdy = 1'b0; tick(); rdy = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("rst_async_cmd", 64'({mc_en, mc_wr, mc_len}), 64'd0);
    chk("rst_async_addr", 64'(mc_addr), 64'd0);
    chk("rst_async_wdata", 64'(mc_wdata), 64'd0);
    chk("rst_async_done", 64'(dones()), 64'd0);
    st_req = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b1; mc_done = 1'b1;
    tick();
    mc_done = 1'b0;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      if (mc_en || dones() != 3'b000) bad = 1;
      tick();
    end
    chk("rst_no_done", 64'(bad), 64'd0);

    // Randomized traffic against the arbitration model.
    starve = 0; busy_own = -1; busy_cyc = 0; mc_cnt = 0; done_sent = 0;
    prev_en = mc_en; p_if = 0; p_ld = 0; p_st = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      dropped_if = 0; dropped_ld = 0; dropped_st = 0;
      mc_done = 1'b0;
      if (mc_en && !prev_en) begin
        if (starve == LIM && p_if) own = 0;
        else if (p_st) own = 2;
        else if (p_ld) own = 1;
        else if (p_if) own = 0;
        else own = -1;
        chk("rnd_owner_valid", 64'(own >= 0), 64'd1);
        chk("rnd_wr", 64'(mc_wr), 64'(own == 2));
        if (own == 0) begin
          chk("rnd_if_addr", 64'(mc_addr), 64'(if_addr));
          chk("rnd_if_len", 64'(mc_len), 64'd0);
          starve = 0;
        end else if (own == 1) begin
          chk("rnd_ld_addr", 64'(mc_addr), 64'(ld_addr));
          chk("rnd_ld_len", 64'(mc_len), 64'(exp_len(ld_len)));
          if (p_if && starve < LIM) starve++;
        end else if (own == 2) begin
          chk("rnd_st_addr", 64'(mc_addr), 64'(st_addr));
          chk("rnd_st_len", 64'(mc_len), 64'(exp_len(st_len)));
          chk("rnd_st_wdata", 64'(mc_wdata), 64'(st_wdata));
          if (p_if && starve < LIM) starve++;
        end
        busy_own = own; busy_cyc = 0; done_sent = 0;
        mc_cnt = $urandom_range(0, 5);
      end
      if (dones() != 3'b000) begin
        chk("rnd_done", 64'(dones()), 64'(oh(busy_own)));
        chk("rnd_done_en", 64'(mc_en), 64'd0);
        if (if_done) begin if_req = 1'b0; dropped_if = 1; end
        if (ld_done) begin ld_req = 1'b0; dropped_ld = 1; end
        if (st_done) begin st_req = 1'b0; dropped_st = 1; end
        busy_own = -1;
      end
      if (mc_en) begin
        busy_cyc++;
        if (busy_cyc > 200) begin
          chk("rnd_timeout", 64'(busy_cyc), 64'd0);
          break;
        end
        if (!done_sent) begin
          if (mc_cnt == 0) begin mc_done = 1'b1; done_sent = 1; end
          else mc_cnt--;
        end
      end
      if (!if_req && !dropped_if && $urandom_range(0, 3) == 0) begin
        if_req = 1'b1; if_addr = $urandom() & 32'hFFFF_FFC0;
      end
      if (!ld_req && !dropped_ld && $urandom_range(0, 3) == 0) begin
        ld_req = 1'b1; ld_addr = $urandom(); ld_len = 3'($urandom_range(0, 7));
      end
      if (!st_req && !dropped_st && $urandom_range(0, 3) == 0) begin
        st_req = 1'b1; st_addr = $urandom(); st_len = 3'($urandom_range(0, 7));
        st_wdata = $urandom();
      end
      rdy = ($urandom_range(0, 4) != 0);
      p_if = if_req; p_ld = ld_req; p_st = st_req;
      prev_en = mc_en;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
